alu_seq: RTL and testbench

//  Single-clock successor to the three-phase-clock ALU. It runs one instruction as up to 3 sequenced phases
//  (push/pop/call/ret/leave/mov/jcc/imm8 arith) using an internal phase counter instead of clock_4/6/8.

---
 rtl/alu_seq_pkg.sv | 46 ++++
 rtl/alu_seq_decode.sv | 120 ++++++++++++
 rtl/alu_seq.sv | 223 ++++++++++++++++++++++
 tb/tb_alu_seq.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared opcodes, modrm bytes and enums for the sequenced ALU.
// Optional flag outputs are enabled by defining ALU_SEQ_FLAGS_EN.
package alu_seq_pkg;

  localparam logic [7:0] OP_PUSH_EBP = 8'h55;
  localparam logic [7:0] OP_PUSH_EAX = 8'h50;
  localparam logic [7:0] OP_PUSH_EBX = 8'h53;
  localparam logic [7:0] OP_MOV_RM   = 8'h89;
  localparam logic [7:0] OP_MOV_IMM  = 8'hb8;
  localparam logic [7:0] OP_POP_EBP  = 8'h5d;
  localparam logic [7:0] OP_RET      = 8'hc3;
  localparam logic [7:0] OP_CALL     = 8'he8;
  localparam logic [7:0] OP_PUSH_IMM = 8'h6a;
  localparam logic [7:0] OP_MOV_RMR  = 8'h8b;
  localparam logic [7:0] OP_LEAVE    = 8'hc9;
  localparam logic [7:0] OP_ADD      = 8'h01;
  localparam logic [7:0] OP_GRP1     = 8'h83;
  localparam logic [7:0] OP_JNZ      = 8'h75;
  localparam logic [7:0] OP_JMP      = 8'heb;

  localparam logic [7:0] MODRM_E8 = 8'he8;
  localparam logic [7:0] MODRM_C4 = 8'hc4;
  localparam logic [7:0] MODRM_EC = 8'hec;
  localparam logic [7:0] MODRM_7D = 8'h7d;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PH1,
    S_PH2,
    S_PH3
  } state_t;

  typedef enum logic [3:0] {
    PASS,
    ADD_STEP,
    SUB_STEP,
    ADD_IMM,
    SUB_IMM,
    DEC1,
    ADD_LEN,
    CALL_TGT,
    IMM24,
    IMM8
  } phase_op_t;

endpackage

// File: rtl/alu_seq_decode.sv
// Instruction word -> phase count, per-phase operations and immediates.
// Purely combinational; 75 consults the live zero flag.
module alu_seq_decode
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [31:0]      ope,
  input  logic             zero,
  output logic [1:0]       n_ph,
  output phase_op_t        op1,
  output phase_op_t        op2,
  output phase_op_t        op3,
  output logic [WIDTH-1:0] imm1,
  output logic [WIDTH-1:0] imm2,
  output logic             illegal
);

  logic [7:0] opc;
  logic [7:0] b1;
  logic [7:0] b2;
  logic [7:0] b3;

  assign opc = ope[31:24];
  assign b1  = ope[23:16];
  assign b2  = ope[15:8];
  assign b3  = ope[7:0];

  function automatic logic [WIDTH-1:0] sext8(input logic [7:0] v);
    return {{(WIDTH-8){v[7]}}, v};
  endfunction

  function automatic logic [WIDTH-1:0] zext8(input logic [7:0] v);
    return {{(WIDTH-8){1'b0}}, v};
  endfunction

  always_comb begin
    n_ph    = 2'd0;
    op1     = PASS;
    op2     = PASS;
    op3     = PASS;
    imm1    = '0;
    imm2    = '0;
    illegal = 1'b0;
    unique case (1'b1)
      (opc == OP_PUSH_EBP || opc == OP_PUSH_EAX ||
       opc == OP_PUSH_EBX): begin
        n_ph = 2'd2;
        op1  = ADD_STEP;
      end
      (opc == OP_MOV_RM): n_ph = 2'd1;
      (opc == OP_MOV_IMM): begin
        n_ph = 2'd1;
        op1  = IMM24;
        imm1 = {{(WIDTH-24){1'b0}}, b3, b2, b1};
      end
      (opc == OP_POP_EBP): begin
        n_ph = 2'd2;
        op2  = SUB_STEP;
      end
      (opc == OP_RET): begin
        n_ph = 2'd2;
        op1  = DEC1;
        op2  = SUB_STEP;
      end
      (opc == OP_CALL): begin
        n_ph = 2'd3;
        op1  = ADD_STEP;
        op2  = ADD_LEN;
        op3  = CALL_TGT;
      end
      (opc == OP_PUSH_IMM): begin
        n_ph = 2'd2;
        op1  = ADD_STEP;
        op2  = IMM8;
        imm2 = zext8(b1);
      end
      (opc == OP_MOV_RMR): begin
        n_ph = 2'd2;
        op1  = ADD_IMM;
        imm1 = sext8(b2);
      end
      (opc == OP_LEAVE): begin
        n_ph = 2'd3;
        op3  = SUB_STEP;
      end
      (opc == OP_ADD): n_ph = 2'd1;
      (opc == OP_GRP1 &&
       (b1 == MODRM_E8 || b1 == MODRM_C4)): begin
        n_ph = 2'd1;
        op1  = SUB_IMM;
        imm1 = zext8(b2);
      end
      (opc == OP_GRP1 && b1 == MODRM_EC): begin
        n_ph = 2'd1;
        op1  = ADD_IMM;
        imm1 = zext8(b2);
      end
      (opc == OP_GRP1 && b1 == MODRM_7D): begin
        n_ph = 2'd2;
        op1  = SUB_IMM;
        op2  = SUB_IMM;
        imm1 = zext8(b2);
        imm2 = zext8({1'b0, b3[7:1]});
      end
      (opc == OP_JNZ): begin
        n_ph = 2'd1;
        op1  = zero ? ADD_IMM : PASS;
        imm1 = sext8(b1);
      end
      (opc == OP_JMP): begin
        n_ph = 2'd1;
        op1  = ADD_IMM;
        imm1 = sext8(b1);
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// Single-clock sequenced ALU: up to 3 phases per instruction.
// Define ALU_SEQ_FLAGS_EN to add flag_z/flag_s/flag_c outputs.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int STACK_STEP = 4,
  parameter int CALL_LEN   = 5
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [31:0]      ope,
  input  logic [3:0]       num_of_ope,
  input  logic             zero,
  input  logic [WIDTH-1:0] registor_in,
  input  logic             phase_ready,
  input  logic             flush,
  output logic             busy,
  output logic [1:0]       phase_no,
  output logic [WIDTH-1:0] alu_result_bus,
  output logic             result_valid,
  output logic             done,
`ifdef ALU_SEQ_FLAGS_EN
  output logic             flag_z,
  output logic             flag_s,
  output logic             flag_c,
`endif
  output logic             illegal
);

  state_t           state;
  state_t           state_nx;
  logic [31:0]      ope_q;
  logic [3:0]       num_q;
  logic             done_q;
  logic             rv_q;
  logic             ill_q;
  logic [WIDTH-1:0] res_q;

  logic [31:0]      dec_ope;
  logic [1:0]       n_ph;
  phase_op_t        op1;
  phase_op_t        op2;
  phase_op_t        op3;
  logic [WIDTH-1:0] imm1;
  logic [WIDTH-1:0] imm2;
  logic             dec_ill;

  // Idle decodes the incoming word; in flight, the latched one.
  assign dec_ope = (state == S_IDLE) ? ope : ope_q;

  alu_seq_decode #(
    .WIDTH(WIDTH)
  ) u_decode (
    .ope    (dec_ope),
    .zero   (zero),
    .n_ph   (n_ph),
    .op1    (op1),
    .op2    (op2),
    .op3    (op3),
    .imm1   (imm1),
    .imm2   (imm2),
    .illegal(dec_ill)
  );

  logic             accept;
  logic             fire;
  logic             last;
  phase_op_t        cur_op;
  logic [WIDTH-1:0] cur_imm;

  always_comb begin
    phase_no = 2'd0;
    cur_op   = PASS;
    cur_imm  = '0;
    unique case (state)
      S_PH1: begin
        phase_no = 2'd1;
        cur_op   = op1;
        cur_imm  = imm1;
      end
      S_PH2: begin
        phase_no = 2'd2;
        cur_op   = op2;
        cur_imm  = imm2;
      end
      S_PH3: begin
        phase_no = 2'd3;
        cur_op   = op3;
      end
      default: ;
    endcase
  end

  // busy covers the done cycle so a start there is dropped.
  assign busy   = (state != S_IDLE) | done_q;
  assign accept = start & ~busy & ~flush;
  assign fire   = (state != S_IDLE) & phase_ready & ~flush;
  assign last   = fire & (phase_no == n_ph);

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (accept && !dec_ill) state_nx = S_PH1;
      S_PH1: begin
        if (flush) state_nx = S_IDLE;
        else if (phase_ready)
          state_nx = (n_ph == 2'd1) ? S_IDLE : S_PH2;
      end
      S_PH2: begin
        if (flush) state_nx = S_IDLE;
        else if (phase_ready)
          state_nx = (n_ph == 2'd2) ? S_IDLE : S_PH3;
      end
      S_PH3: begin
        if (flush || phase_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  logic [WIDTH-1:0] rel;
  logic [WIDTH-1:0] call_off;
  logic [WIDTH-1:0] opb;
  logic             sub;
  logic             pass;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] alu_out;

  assign rel = {{(WIDTH-24){ope_q[7]}},
                ope_q[7:0], ope_q[15:8], ope_q[23:16]};
  assign call_off = rel + WIDTH'(num_q) - WIDTH'(CALL_LEN);

  always_comb begin
    opb  = '0;
    sub  = 1'b0;
    pass = 1'b0;
    unique case (cur_op)
      ADD_STEP: opb = WIDTH'(STACK_STEP);
      SUB_STEP: begin
        opb = WIDTH'(STACK_STEP);
        sub = 1'b1;
      end
      ADD_IMM: opb = cur_imm;
      SUB_IMM: begin
        opb = cur_imm;
        sub = 1'b1;
      end
      DEC1: begin
        opb = WIDTH'(1);
        sub = 1'b1;
      end
      ADD_LEN:  opb = WIDTH'(num_q);
      CALL_TGT: opb = call_off;
      default:  pass = 1'b1;
    endcase
  end

`ifdef ALU_SEQ_FLAGS_EN
  logic [WIDTH:0] sum_x;
  logic           carry;
  assign sum_x = {1'b0, registor_in}
               + {1'b0, sub ? ~opb : opb}
               + {{WIDTH{1'b0}}, sub};
  assign sum   = sum_x[WIDTH-1:0];
  // Subtraction reports borrow, i.e. the inverted carry.
  assign carry = pass ? 1'b0 : (sum_x[WIDTH] ^ sub);
`else
  assign sum = registor_in
             + (sub ? ~opb : opb)
             + {{(WIDTH-1){1'b0}}, sub};
`endif

  assign alu_out = !pass ? sum :
                   (cur_op == IMM24 || cur_op == IMM8) ? cur_imm :
                   registor_in;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ope_q  <= '0;
      num_q  <= '0;
      done_q <= 1'b0;
      rv_q   <= 1'b0;
      ill_q  <= 1'b0;
      res_q  <= '0;
    end else begin
      if (accept) begin
        ope_q <= ope;
        num_q <= num_of_ope;
      end
      rv_q   <= fire;
      done_q <= last | (accept & dec_ill);
      ill_q  <= accept & dec_ill;
      if (fire) res_q <= alu_out;
    end
  end

`ifdef ALU_SEQ_FLAGS_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      flag_z <= 1'b0;
      flag_s <= 1'b0;
      flag_c <= 1'b0;
    end else if (fire) begin
      flag_z <= (alu_out == '0);
      flag_s <= alu_out[WIDTH-1];
      flag_c <= carry;
    end
  end
`endif

  assign alu_result_bus = res_q;
  assign result_valid   = rv_q;
  assign done           = done_q;
  assign illegal        = ill_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq.
// Flag checks are included when ALU_SEQ_FLAGS_EN is defined.
module tb_alu_seq;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] ope = '0;
  logic [3:0]  num_of_ope = '0;
  logic        zero = 1'b0;
  logic [31:0] registor_in = '0;
  logic        phase_ready = 1'b0;
  logic        flush = 1'b0;
  logic        busy;
  logic [1:0]  phase_no;
  logic [31:0] alu_result_bus;
  logic        result_valid;
  logic        done;
  logic        illegal;
`ifdef ALU_SEQ_FLAGS_EN
  logic        flag_z;
  logic        flag_s;
  logic        flag_c;
`endif

  int vectors = 0;
  int miscompares = 0;

  alu_seq dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .start         (start),
    .ope           (ope),
    .num_of_ope    (num_of_ope),
    .zero          (zero),
    .registor_in   (registor_in),
    .phase_ready   (phase_ready),
    .flush         (flush),
    .busy          (busy),
    .phase_no      (phase_no),
    .alu_result_bus(alu_result_bus),
    .result_valid  (result_valid),
    .done          (done),
`ifdef ALU_SEQ_FLAGS_EN
    .flag_z        (flag_z),
    .flag_s        (flag_s),
    .flag_c        (flag_c),
`endif
    .illegal       (illegal)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic run(input string tag,
                     input logic [31:0] op,
                     input logic [3:0] num,
                     input logic [31:0] r,
                     input logic z,
                     input int n,
                     input logic [31:0] e0,
                     input logic [31:0] e1,
                     input logic [31:0] e2);
    logic [31:0] exp [3];
    exp[0] = e0;
    exp[1] = e1;
    exp[2] = e2;
    ope = op;
    num_of_ope = num;
    registor_in = r;
    zero = z;
    phase_ready = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int k = 0; k < n; k++) begin
      check($sformatf("%s_ph%0d", tag, k), 32'(phase_no), k + 1);
      tick;
      check($sformatf("%s_rv%0d", tag, k), 32'(result_valid), 1);
      check($sformatf("%s_res%0d", tag, k), alu_result_bus, exp[k]);
      check($sformatf("%s_done%0d", tag, k), 32'(done),
            (k == n - 1) ? 1 : 0);
    end
    check({tag, "_busy_done"}, 32'(busy), 1);
    tick;
    check({tag, "_idle"}, 32'(busy), 0);
  endtask

  initial begin
    tick;
    tick;
    check("rst_busy", 32'(busy), 0);
    check("rst_ph", 32'(phase_no), 0);
    check("rst_res", alu_result_bus, 0);
    check("rst_rv", 32'(result_valid), 0);
    check("rst_done", 32'(done), 0);
    check("rst_ill", 32'(illegal), 0);
    reset_n = 1'b1;
    tick;

    run("push", 32'h5500_0000, 4'd1, 32'h100, 1'b0, 2,
        32'h104, 32'h100, 32'h0);
    run("push_wrap", 32'h5000_0000, 4'd1, 32'hFFFF_FFFE, 1'b0, 2,
        32'h2, 32'hFFFF_FFFE, 32'h0);
    run("call", 32'hE8EE_FFFF, 4'd5, 32'h20, 1'b0, 3,
        32'h24, 32'h25, 32'h0E);
    run("movrm", 32'h8B45_F800, 4'd3, 32'h200, 1'b0, 2,
        32'h1F8, 32'h200, 32'h0);
    run("jnz_t", 32'h75FE_0000, 4'd2, 32'h10, 1'b1, 1,
        32'h0E, 32'h0, 32'h0);
    run("jnz_f", 32'h75FE_0000, 4'd2, 32'h10, 1'b0, 1,
        32'h10, 32'h0, 32'h0);
    run("jmp", 32'hEB05_0000, 4'd2, 32'h100, 1'b0, 1,
        32'h105, 32'h0, 32'h0);
    run("movimm", 32'hB812_3456, 4'd5, 32'h77, 1'b0, 1,
        32'h0056_3412, 32'h0, 32'h0);
    run("movr", 32'h89C0_0000, 4'd2, 32'h77, 1'b0, 1,
        32'h77, 32'h0, 32'h0);
    run("pushi", 32'h6A80_0000, 4'd2, 32'h100, 1'b0, 2,
        32'h104, 32'h80, 32'h0);
    run("grp7d", 32'h837D_1009, 4'd4, 32'h100, 1'b0, 2,
        32'hF0, 32'hFC, 32'h0);
    run("addesp", 32'h83EC_1000, 4'd3, 32'h100, 1'b0, 1,
        32'h110, 32'h0, 32'h0);

    run("subz", 32'h83C4_0800, 4'd3, 32'h08, 1'b0, 1,
        32'h0, 32'h0, 32'h0);
`ifdef ALU_SEQ_FLAGS_EN
    check("subz_fz", 32'(flag_z), 1);
    check("subz_fs", 32'(flag_s), 0);
    check("subz_fc", 32'(flag_c), 0);
`endif
    run("subb", 32'h83C4_0800, 4'd3, 32'h04, 1'b0, 1,
        32'hFFFF_FFFC, 32'h0, 32'h0);
`ifdef ALU_SEQ_FLAGS_EN
    check("subb_fz", 32'(flag_z), 0);
    check("subb_fs", 32'(flag_s), 1);
    check("subb_fc", 32'(flag_c), 1);
`endif

    // ret with a 3-cycle stall in phase 2
    ope = 32'hC300_0000;
    registor_in = 32'h40;
    phase_ready = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    check("ret_r1", alu_result_bus, 32'h3F);
    phase_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      check("ret_stall_busy", 32'(busy), 1);
      check("ret_stall_rv", 32'(result_valid), 0);
      check("ret_stall_ph", 32'(phase_no), 2);
    end
    phase_ready = 1'b1;
    tick;
    check("ret_r2", alu_result_bus, 32'h3C);
    check("ret_done", 32'(done), 1);
    tick;
    check("ret_idle", 32'(busy), 0);

    // leave flushed in phase 2, flush beats phase_ready
    ope = 32'hC900_0000;
    registor_in = 32'h80;
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    check("lv_r1", alu_result_bus, 32'h80);
    check("lv_ph2", 32'(phase_no), 2);
    flush = 1'b1;
    registor_in = 32'h99;
    tick;
    flush = 1'b0;
    check("fl_rv", 32'(result_valid), 0);
    check("fl_done", 32'(done), 0);
    check("fl_busy", 32'(busy), 0);
    check("fl_hold", alu_result_bus, 32'h80);

    // start while busy is ignored
    ope = 32'h5D00_0000;
    registor_in = 32'h50;
    phase_ready = 1'b0;
    start = 1'b1;
    tick;
    ope = 32'hFF00_0000;
    tick;
    check("sb_ill", 32'(illegal), 0);
    check("sb_ph", 32'(phase_no), 1);
    start = 1'b0;
    phase_ready = 1'b1;
    tick;
    check("sb_r1", alu_result_bus, 32'h50);
    tick;
    check("sb_r2", alu_result_bus, 32'h4C);
    check("sb_done", 32'(done), 1);

    // start in the done cycle is dropped
    ope = 32'h0100_0000;
    start = 1'b1;
    tick;
    start = 1'b0;
    check("sd_busy", 32'(busy), 0);
    check("sd_ph", 32'(phase_no), 0);
    tick;
    check("sd_rv", 32'(result_valid), 0);

    // unknown opcode
    ope = 32'hFF00_0000;
    start = 1'b1;
    tick;
    start = 1'b0;
    check("ill_pulse", 32'(illegal), 1);
    check("ill_done", 32'(done), 1);
    check("ill_rv", 32'(result_valid), 0);
    check("ill_hold", alu_result_bus, 32'h4C);
    tick;
    check("ill_clr", 32'(illegal), 0);
    check("ill_idle", 32'(busy), 0);

    // unknown 83 modrm
    ope = 32'h8300_0000;
    start = 1'b1;
    tick;
    start = 1'b0;
    check("ill83", 32'(illegal), 1);
    tick;

    // reset in the middle of a call
    ope = 32'hE8EE_FFFF;
    num_of_ope = 4'd5;
    registor_in = 32'h20;
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    check("mr_r1", alu_result_bus, 32'h24);
    reset_n = 1'b0;
    #1;
    check("mr_busy", 32'(busy), 0);
    check("mr_ph", 32'(phase_no), 0);
    check("mr_done", 32'(done), 0);
    check("mr_res", alu_result_bus, 0);
    tick;
    reset_n = 1'b1;
    tick;
    check("mr_idle", 32'(busy), 0);
    check("mr_nodone", 32'(done), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
